// File: rtl/mtr_ramp_ctrl_pkg.sv
// Shared types and constants for the two-wheel motor speed ramp controller.
package mtr_ramp_ctrl_pkg;
  localparam int SPD_W      = 11;
  localparam int PERIOD_MAX = 2047;

  typedef enum logic [1:0] {IDLE, RAMP, HOLD} ramp_state_e;
endpackage

// File: rtl/wheel_ramp.sv
// One wheel's speed/direction ramp: steps toward the target once per PWM period,
// passing through zero and a hold interval whenever the direction has to flip.
module wheel_ramp
  import mtr_ramp_ctrl_pkg::*;
#(
  parameter int RAMP_STEP    = 64,
  parameter int HOLD_PERIODS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             accept,
  input  logic [SPD_W-1:0] cmd_spd,
  input  logic             cmd_rev,
  output logic [SPD_W-1:0] spd,
  output logic             rev,
  output logic             busy
);

  localparam logic [SPD_W:0] STEP_W    = (SPD_W+1)'(RAMP_STEP);
  localparam logic [15:0]    HOLD_LAST = 16'(HOLD_PERIODS - 1);

  ramp_state_e      state, state_nx;
  logic [SPD_W-1:0] spd_nx, tgt_spd, tgt_spd_nx, stepped;
  logic             rev_nx, tgt_rev, tgt_rev_nx, dir_ok;
  logic [15:0]      hold_cnt, hold_nx;

  // One step toward tgt, computed one bit wider so neither end can wrap.
  function automatic logic [SPD_W-1:0] step_toward(input logic [SPD_W-1:0] cur,
                                                   input logic [SPD_W-1:0] tgt);
    logic [SPD_W:0] cur_w, tgt_w, sum_w, gap_w, dif_w;
    cur_w = {1'b0, cur};
    tgt_w = {1'b0, tgt};
    sum_w = cur_w + STEP_W;
    gap_w = cur_w - tgt_w;
    dif_w = cur_w - STEP_W;
    if (cur_w < tgt_w)
      step_toward = (sum_w >= tgt_w) ? tgt : sum_w[SPD_W-1:0];
    else
      step_toward = (gap_w <= STEP_W) ? tgt : dif_w[SPD_W-1:0];
  endfunction

  always_comb begin
    state_nx   = state;
    spd_nx     = spd;
    rev_nx     = rev;
    tgt_spd_nx = tgt_spd;
    tgt_rev_nx = tgt_rev;
    hold_nx    = hold_cnt;
    stepped    = '0;
    // A zero target is reached in whatever direction the wheel already has.
    dir_ok     = (rev == tgt_rev) || (tgt_spd == '0);
    case (state)
      IDLE: begin
        if (accept) begin
          tgt_spd_nx = cmd_spd;
          tgt_rev_nx = cmd_rev;
          state_nx   = RAMP;
        end
      end
      RAMP: begin
        if (tick) begin
          if (dir_ok) begin
            stepped = step_toward(spd, tgt_spd);
            spd_nx  = stepped;
            if (stepped == tgt_spd) state_nx = IDLE;
          end else begin
            stepped = step_toward(spd, '0);
            spd_nx  = stepped;
            if (stepped == '0) begin
              state_nx = HOLD;
              hold_nx  = '0;
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          if (hold_cnt == HOLD_LAST) begin
            rev_nx   = ~rev;
            state_nx = RAMP;
          end else begin
            hold_nx = hold_cnt + 16'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      spd      <= '0;
      rev      <= 1'b0;
      tgt_spd  <= '0;
      tgt_rev  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      spd      <= spd_nx;
      rev      <= rev_nx;
      tgt_spd  <= tgt_spd_nx;
      tgt_rev  <= tgt_rev_nx;
      hold_cnt <= hold_nx;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: rtl/mtr_ramp_ctrl.sv
// Two-wheel ramp controller: accepts a target pair when idle and steps both wheels
// toward it in phase with the motor driver's 2048-cycle PWM period.
module mtr_ramp_ctrl
  import mtr_ramp_ctrl_pkg::*;
#(
  parameter int RAMP_STEP    = 64,
  parameter int HOLD_PERIODS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_vld,
  output logic             cmd_rdy,
  input  logic [SPD_W-1:0] cmd_lft_spd,
  input  logic [SPD_W-1:0] cmd_rght_spd,
  input  logic             cmd_lft_rev,
  input  logic             cmd_rght_rev,
  output logic [SPD_W-1:0] lft_spd,
  output logic [SPD_W-1:0] rght_spd,
  output logic             lft_rev,
  output logic             rght_rev,
  output logic             busy
);

  logic [SPD_W-1:0] prd_cnt;
  logic             tick, accept, lft_busy, rght_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prd_cnt <= '0;
    else        prd_cnt <= prd_cnt + SPD_W'(1);
  end

  assign tick    = (prd_cnt == SPD_W'(PERIOD_MAX));
  assign busy    = lft_busy | rght_busy;
  assign cmd_rdy = ~busy;
  assign accept  = cmd_vld & cmd_rdy;

  wheel_ramp #(.RAMP_STEP(RAMP_STEP), .HOLD_PERIODS(HOLD_PERIODS)) u_lft (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .accept  (accept),
    .cmd_spd (cmd_lft_spd),
    .cmd_rev (cmd_lft_rev),
    .spd     (lft_spd),
    .rev     (lft_rev),
    .busy    (lft_busy)
  );

  wheel_ramp #(.RAMP_STEP(RAMP_STEP), .HOLD_PERIODS(HOLD_PERIODS)) u_rght (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .accept  (accept),
    .cmd_spd (cmd_rght_spd),
    .cmd_rev (cmd_rght_rev),
    .spd     (rght_spd),
    .rev     (rght_rev),
    .busy    (rght_busy)
  );

endmodule

// File: tb/tb_mtr_ramp_ctrl.sv
// Scoreboard bench for mtr_ramp_ctrl: a default instance and a large-step instance
// (step 500, two hold periods) so the full-scale ramps fit in a short run.
module tb_mtr_ramp_ctrl;

  typedef struct packed {
    logic [10:0] ls;
    logic        lr;
    logic [10:0] rs;
    logic        rr;
  } out_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        cmd_vld, cmd_rdy, cmd_lft_rev, cmd_rght_rev, lft_rev, rght_rev, busy;
  logic [10:0] cmd_lft_spd, cmd_rght_spd, lft_spd, rght_spd;
  logic        f_cmd_vld, f_cmd_rdy, f_cmd_lft_rev, f_cmd_rght_rev, f_lft_rev, f_rght_rev, f_busy;
  logic [10:0] f_cmd_lft_spd, f_cmd_rght_spd, f_lft_spd, f_rght_spd;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [10:0] tb_cnt;
  out_t        q_m[$];
  out_t        q_f[$];
  out_t        prev_m, prev_f;

  always #5 clk = ~clk;

  mtr_ramp_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_lft_spd(cmd_lft_spd), .cmd_rght_spd(cmd_rght_spd),
    .cmd_lft_rev(cmd_lft_rev), .cmd_rght_rev(cmd_rght_rev),
    .lft_spd(lft_spd), .rght_spd(rght_spd), .lft_rev(lft_rev), .rght_rev(rght_rev),
    .busy(busy)
  );

  mtr_ramp_ctrl #(.RAMP_STEP(500), .HOLD_PERIODS(2)) u_fast (
    .clk(clk), .rst_n(rst_n), .cmd_vld(f_cmd_vld), .cmd_rdy(f_cmd_rdy),
    .cmd_lft_spd(f_cmd_lft_spd), .cmd_rght_spd(f_cmd_rght_spd),
    .cmd_lft_rev(f_cmd_lft_rev), .cmd_rght_rev(f_cmd_rght_rev),
    .lft_spd(f_lft_spd), .rght_spd(f_rght_spd), .lft_rev(f_lft_rev), .rght_rev(f_rght_rev),
    .busy(f_busy)
  );

  // Reference period counter: outputs may only move on the edge that wraps it to 0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cnt <= '0;
    else        tb_cnt <= tb_cnt + 11'd1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void push(input bit f, input int ls, input bit lr, input int rs, input bit rr);
    out_t o;
    o.ls = 11'(ls);
    o.lr = lr;
    o.rs = 11'(rs);
    o.rr = rr;
    if (f) q_f.push_back(o);
    else   q_m.push_back(o);
  endfunction

  task automatic mon_step(input string nm, input out_t cur, input out_t prv,
                          input bit have, input out_t e);
    check({nm, "_tick_align"}, int'(tb_cnt), 0);
    if (cur.lr != prv.lr) check({nm, "_lrev_at_zero"}, int'(prv.ls | cur.ls), 0);
    if (cur.rr != prv.rr) check({nm, "_rrev_at_zero"}, int'(prv.rs | cur.rs), 0);
    check({nm, "_expected_change"}, int'(have), 1);
    if (have) begin
      check({nm, "_lft_spd"},  int'(cur.ls), int'(e.ls));
      check({nm, "_lft_rev"},  int'(cur.lr), int'(e.lr));
      check({nm, "_rght_spd"}, int'(cur.rs), int'(e.rs));
      check({nm, "_rght_rev"}, int'(cur.rr), int'(e.rr));
    end
  endtask

  always @(negedge clk) begin
    out_t cur, e;
    bit   have;
    cur = {lft_spd, lft_rev, rght_spd, rght_rev};
    if (!rst_n) prev_m = cur;
    else if (cur != prev_m) begin
      have = (q_m.size() > 0);
      e    = '0;
      if (have) e = q_m.pop_front();
      mon_step("m", cur, prev_m, have, e);
      prev_m = cur;
    end
  end

  always @(negedge clk) begin
    out_t cur, e;
    bit   have;
    cur = {f_lft_spd, f_lft_rev, f_rght_spd, f_rght_rev};
    if (!rst_n) prev_f = cur;
    else if (cur != prev_f) begin
      have = (q_f.size() > 0);
      e    = '0;
      if (have) e = q_f.pop_front();
      mon_step("f", cur, prev_f, have, e);
      prev_f = cur;
    end
  end

  task automatic send(input bit f, input int ls, input bit lr, input int rs, input bit rr,
                      input bit at_tick);
    int    n;
    string pre;
    n   = 0;
    pre = f ? "f" : "m";
    @(negedge clk);
    while (((f ? f_cmd_rdy : cmd_rdy) !== 1'b1 || (at_tick && tb_cnt != 11'd2047)) && n <= 4096) begin
      @(negedge clk);
      n++;
    end
    check({pre, "_rdy_wait"}, int'(n <= 4096), 1);
    if (f) begin
      f_cmd_vld = 1'b1; f_cmd_lft_spd = 11'(ls); f_cmd_lft_rev = lr;
      f_cmd_rght_spd = 11'(rs); f_cmd_rght_rev = rr;
    end else begin
      cmd_vld = 1'b1; cmd_lft_spd = 11'(ls); cmd_lft_rev = lr;
      cmd_rght_spd = 11'(rs); cmd_rght_rev = rr;
    end
    @(negedge clk);
    if (f) f_cmd_vld = 1'b0;
    else   cmd_vld = 1'b0;
    check({pre, "_busy_after_accept"}, int'(f ? f_busy : busy), 1);
    check({pre, "_rdy_after_accept"}, int'(f ? f_cmd_rdy : cmd_rdy), 0);
  endtask

  task automatic wait_idle(input bit f, input int exp_ticks, input string tag);
    int n_tick, cyc;
    n_tick = 0;
    cyc    = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (tb_cnt == 11'd0) n_tick++;
    end while ((f ? f_busy : busy) && cyc < 20 * 2048);
    #1;
    check({tag, "_idle"}, int'(f ? f_busy : busy), 0);
    check({tag, "_ticks"}, n_tick, exp_ticks);
    check({tag, "_drained"}, f ? q_f.size() : q_m.size(), 0);
  endtask

  initial begin
    int n;
    cmd_vld = 1'b0; cmd_lft_spd = '0; cmd_rght_spd = '0; cmd_lft_rev = 1'b0; cmd_rght_rev = 1'b0;
    f_cmd_vld = 1'b0; f_cmd_lft_spd = '0; f_cmd_rght_spd = '0; f_cmd_lft_rev = 1'b0; f_cmd_rght_rev = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_lft_spd", int'(lft_spd), 0);
    check("rst_rght_spd", int'(rght_spd), 0);
    check("rst_revs", int'({lft_rev, rght_rev}), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    #1;
    check("rel_cmd_rdy", int'(cmd_rdy), 1);
    check("rel_f_cmd_rdy", int'(f_cmd_rdy), 1);

    fork
      begin
        push(0, 64, 0, 0, 0); push(0, 128, 0, 0, 0); push(0, 192, 0, 0, 0); push(0, 200, 0, 0, 0);
        send(0, 200, 0, 0, 0, 0);
        wait_idle(0, 4, "ramp_up");
        push(0, 136, 0, 0, 0); push(0, 100, 0, 0, 0);
        send(0, 100, 0, 0, 0, 0);
        wait_idle(0, 2, "ramp_down");
        push(0, 36, 0, 0, 0); push(0, 0, 0, 0, 0); push(0, 0, 1, 0, 0);
        push(0, 64, 1, 0, 0); push(0, 100, 1, 0, 0);
        send(0, 100, 1, 0, 0, 0);
        wait_idle(0, 5, "reverse");
      end
      begin
        push(1, 0, 0, 500, 0); push(1, 0, 0, 1000, 0); push(1, 0, 0, 1500, 0); push(1, 0, 0, 2000, 0);
        send(1, 0, 0, 2000, 0, 0);
        wait_idle(1, 4, "f_to_2000");
        push(1, 0, 0, 2047, 0);
        send(1, 0, 0, 2047, 0, 0);
        wait_idle(1, 1, "f_no_wrap");
        push(1, 0, 0, 1547, 0); push(1, 0, 0, 1047, 0); push(1, 0, 0, 547, 0);
        push(1, 0, 0, 47, 0); push(1, 0, 0, 0, 0);
        send(1, 0, 0, 0, 0, 0);
        wait_idle(1, 5, "f_to_zero");
        push(1, 0, 1, 0, 0); push(1, 300, 1, 0, 0);
        send(1, 300, 1, 0, 0, 0);
        wait_idle(1, 4, "f_hold2");
      end
    join

    // Command while busy must be dropped; the ramp continues to 300.
    push(0, 164, 1, 0, 0); push(0, 228, 1, 0, 0); push(0, 292, 1, 0, 0); push(0, 300, 1, 0, 0);
    send(0, 300, 1, 0, 0, 0);
    @(negedge clk);
    check("busy_cmd_rdy", int'(cmd_rdy), 0);
    cmd_vld = 1'b1; cmd_lft_spd = 11'd0; cmd_lft_rev = 1'b0; cmd_rght_spd = 11'd500; cmd_rght_rev = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
    wait_idle(0, 4, "ignore_busy");

    // Accept on a tick edge, zero target forward while reversed: no step, no flip.
    push(0, 236, 1, 0, 0); push(0, 172, 1, 0, 0); push(0, 108, 1, 0, 0);
    push(0, 44, 1, 0, 0); push(0, 0, 1, 0, 0);
    send(0, 0, 0, 0, 0, 1);
    check("coinc_no_step", int'(lft_spd), 300);
    wait_idle(0, 5, "coinc");

    push(0, 0, 1, 64, 0); push(0, 0, 1, 128, 0);
    send(0, 0, 1, 128, 0, 0);
    wait_idle(0, 2, "rght_up");
    push(0, 0, 1, 64, 0); push(0, 0, 1, 0, 0);
    send(0, 0, 1, 128, 1, 0);
    n = 0;
    while (q_m.size() > 0 && n < 3 * 2048) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("hold_reached", int'(q_m.size() == 0), 1);
    check("hold_busy", int'(busy), 1);
    #100;
    rst_n = 1'b0;
    #1;
    check("async_lft_rev", int'(lft_rev), 0);
    check("async_rght_rev", int'(rght_rev), 0);
    check("async_spds", int'(lft_spd | rght_spd), 0);
    check("async_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rerel_cmd_rdy", int'(cmd_rdy), 1);
    push(0, 64, 0, 0, 0);
    send(0, 64, 0, 0, 0, 0);
    wait_idle(0, 1, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
